// File: rtl/en_clk_pkg.sv
// Shared helpers for the en_clk_multi enable generator: divider ratio and index widths.
// Pure constants and functions; no logic, no latency, no flow control.
package en_clk_pkg;

  function automatic int unsigned pre_div(input int unsigned clk_hz, input int unsigned base_hz);
    return clk_hz / base_hz;
  endfunction

  // Channel index bus stays at least one bit wide so a single-channel build still has a port.
  function automatic int unsigned ch_idx_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  localparam int unsigned PRE_DIV_DEFAULT = pre_div(50_000_000, 100);
  localparam int unsigned CNT_W_MIN       = $clog2(PRE_DIV_DEFAULT);

endpackage

// File: rtl/en_div_ch.sv
// One channel divider: counts base ticks and emits a one-cycle en every div ticks.
// Registered output, one cycle after the qualifying tick; no backpressure, div==0 parks the channel.
module en_div_ch
  import en_clk_pkg::*;
#(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DIV_INIT = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic             ld,
  input  logic [DIV_W-1:0] ld_div,
  output logic             en,
  output logic [DIV_W-1:0] div
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             en_q, en_d;

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    en_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      // A reload restarts the phase and swallows any pulse due on this edge.
      div_d = ld_div;
      cnt_d = '0;
    end else if (tick && (div_q != '0)) begin
      if (cnt_q == div_q - DIV_W'(1)) begin
        cnt_d = '0;
        en_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      div_q <= DIV_W'(DIV_INIT);
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      en_q  <= en_d;
    end
  end

  assign en  = en_q;
  assign div = div_q;

endmodule

// File: rtl/en_clk_multi.sv
// Base prescaler plus NCH reloadable channel dividers producing one-cycle enable strobes.
// All outputs registered (one cycle after the terminal count); no backpressure, run=0 freezes.
module en_clk_multi
  import en_clk_pkg::*;
#(
  parameter  int unsigned CLK_HZ   = 50_000_000,
  parameter  int unsigned BASE_HZ  = 100,
  parameter  int unsigned CNT_W    = 26,
  parameter  int unsigned NCH      = 4,
  parameter  int unsigned DIV_W    = 8,
  parameter  int unsigned DIV_INIT = 100,
  localparam int unsigned CH_W     = ch_idx_w(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic             load,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [DIV_W-1:0] load_div,
  output logic             load_ack,
  output logic             en_base,
  output logic [NCH-1:0]   en_ch
);

  localparam int unsigned PRE_DIV = pre_div(CLK_HZ, BASE_HZ);

  if (CLK_HZ % BASE_HZ != 0) begin : g_err_ratio
    $error("en_clk_multi: CLK_HZ must be an integer multiple of BASE_HZ");
  end
  if (PRE_DIV < 2) begin : g_err_prediv
    $error("en_clk_multi: CLK_HZ/BASE_HZ must be at least 2");
  end
  if ((64'(PRE_DIV) - 64'd1) >= (64'd1 << CNT_W)) begin : g_err_cntw
    $error("en_clk_multi: CNT_W too narrow for PRE_DIV-1");
  end
  if (64'(DIV_INIT) >= (64'd1 << DIV_W)) begin : g_err_divinit
    $error("en_clk_multi: DIV_INIT does not fit in DIV_W");
  end
  if ((NCH < 1) || (NCH > 16)) begin : g_err_nch
    $error("en_clk_multi: NCH must be in 1..16");
  end

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_DIV - 1);

  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             en_base_q, en_base_d;
  logic             load_ack_q, load_ack_d;
  logic             tick;
  logic             load_ok;
  logic [NCH-1:0]   ch_ld;
  logic [DIV_W-1:0] div_unused [NCH];

  always_comb begin
    tick       = run && (pre_cnt_q == PRE_LAST);
    // clr outranks load, and out-of-range channel indices are dropped without an ack.
    load_ok    = load && !clr && (32'(load_ch) < NCH);
    load_ack_d = load_ok;
    pre_cnt_d  = pre_cnt_q;
    en_base_d  = 1'b0;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
      en_base_d = 1'b1;
    end else if (run) begin
      pre_cnt_d = pre_cnt_q + CNT_W'(1);
    end
    ch_ld = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_ld[i] = load_ok && (load_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt_q  <= '0;
      en_base_q  <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      en_base_q  <= en_base_d;
      load_ack_q <= load_ack_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    en_div_ch #(
      .DIV_W   (DIV_W),
      .DIV_INIT(DIV_INIT)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .tick  (tick),
      .ld    (ch_ld[i]),
      .ld_div(load_div),
      .en    (en_ch[i]),
      .div   (div_unused[i])
    );
  end

  assign en_base  = en_base_q;
  assign load_ack = load_ack_q;

endmodule

// File: tb/tb_en_clk_multi.sv
// Bench for en_clk_multi: small config (PRE_DIV=10, 3 channels) plus a scaled long-period config.
module tb_en_clk_multi;

  localparam int NCH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, run, clr, load;
  logic [1:0]     load_ch;
  logic [7:0]     load_div;
  logic           load_ack, en_base;
  logic [NCH-1:0] en_ch;

  en_clk_multi #(
    .CLK_HZ(100), .BASE_HZ(10), .CNT_W(4), .NCH(NCH), .DIV_W(8), .DIV_INIT(3)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .load(load), .load_ch(load_ch),
    .load_div(load_div), .load_ack(load_ack), .en_base(en_base), .en_ch(en_ch)
  );

  logic       rst2, run2, clr2, load2;
  logic [1:0] load_ch2;
  logic [7:0] load_div2;
  logic       load_ack2, en_base2;
  logic [3:0] en_ch2;

  en_clk_multi #(
    .CLK_HZ(1000), .BASE_HZ(10), .CNT_W(26), .NCH(4), .DIV_W(8), .DIV_INIT(100)
  ) dut2 (
    .clk(clk), .rst(rst2), .run(run2), .clr(clr2), .load(load2), .load_ch(load_ch2),
    .load_div(load_div2), .load_ack(load_ack2), .en_base(en_base2), .en_ch(en_ch2)
  );

  typedef struct packed {
    logic           b;
    logic [NCH-1:0] ch;
    logic           ack;
  } exp_t;

  typedef struct {
    logic       r, ru, c, l;
    logic [1:0] lc;
    logic [7:0] ld;
    int         n;
    int         eb, e0, e1, e2, ea;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[21];
  int   checks = 0;
  int   errors = 0;
  int   cnt_b, cnt_a;
  int   cnt_c[NCH];

  // Reference state, written straight from the behavioural description.
  int m_pre;
  int m_cnt[NCH];
  int m_div[NCH];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({en_base, en_ch, load_ack} !== e) begin
        errors++;
        $display("FAIL cycle_out t=%0t: got b=%b ch=%b ack=%b expected b=%b ch=%b ack=%b",
                 $time, en_base, en_ch, load_ack, e.b, e.ch, e.ack);
      end
      if (en_base === 1'b1) cnt_b++;
      if (load_ack === 1'b1) cnt_a++;
      for (int i = 0; i < NCH; i++) if (en_ch[i] === 1'b1) cnt_c[i]++;
    end
  end

  task automatic drive(input logic r, input logic ru, input logic c, input logic l,
                       input logic [1:0] lc, input logic [7:0] ld);
    exp_t e;
    bit   tk;
    rst = r; run = ru; clr = c; load = l; load_ch = lc; load_div = ld;
    e = '0;
    if (!r) begin
      m_pre = 0;
      for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_div[i] = 3; end
    end else if (c) begin
      m_pre = 0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    end else begin
      tk  = ru && (m_pre == 9);
      e.b = tk;
      if (ru) m_pre = tk ? 0 : m_pre + 1;
      e.ack = l && (lc < NCH);
      for (int i = 0; i < NCH; i++) begin
        if (e.ack && (lc == i)) begin
          m_div[i] = ld;
          m_cnt[i] = 0;
        end else if (tk && m_div[i] != 0) begin
          if (m_cnt[i] == m_div[i] - 1) begin
            m_cnt[i] = 0;
            e.ch[i]  = 1'b1;
          end else begin
            m_cnt[i]++;
          end
        end
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  int tb_t[3];
  int tc_t[2];
  int nb, nc;

  initial begin
    rst = 1'b0; run = 1'b0; clr = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
    rst2 = 1'b0; run2 = 1'b1; clr2 = 1'b0; load2 = 1'b0; load_ch2 = '0; load_div2 = '0;

    //          r     ru    c     l     lc    ld    n    eb e0 e1 e2 ea
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 3,   0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 30,  3, 1, 1, 1, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 5,   0, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 7,   0, 0, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 5,   1, 0, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 19,  1, 0, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 8'd1, 1,   1, 1, 0, 1, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 30,  3, 1, 3, 1, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'd0, 1,   0, 0, 0, 0, 1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 100, 10, 0, 10, 3, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'd5, 3,   0, 0, 0, 0, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1,   0, 0, 0, 0, 0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'd7, 2,   0, 0, 0, 0, 0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 30,  3, 0, 3, 1, 0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 5,   0, 0, 0, 0, 0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 1,   0, 0, 0, 0, 0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 30,  3, 1, 1, 1, 0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd2, 1,   0, 0, 0, 0, 1};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 20,  2, 0, 1, 0, 0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'd4, 3,   0, 0, 0, 0, 3};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 40,  4, 1, 2, 2, 0};

    for (int r = 0; r < 21; r++) begin
      cnt_b = 0; cnt_a = 0;
      for (int i = 0; i < NCH; i++) cnt_c[i] = 0;
      for (int k = 0; k < tbl[r].n; k++)
        drive(tbl[r].r, tbl[r].ru, tbl[r].c, tbl[r].l, tbl[r].lc, tbl[r].ld);
      chk($sformatf("row%0d en_base count", r), cnt_b, tbl[r].eb);
      chk($sformatf("row%0d en_ch0 count", r), cnt_c[0], tbl[r].e0);
      chk($sformatf("row%0d en_ch1 count", r), cnt_c[1], tbl[r].e1);
      chk($sformatf("row%0d en_ch2 count", r), cnt_c[2], tbl[r].e2);
      chk($sformatf("row%0d load_ack count", r), cnt_a, tbl[r].ea);
    end
    chk("scoreboard drained", sb_q.size(), 0);

    // Long-period configuration: PRE_DIV=100, channel divisor 100 from reset.
    nb = 0; nc = 0;
    tb_t = '{0, 0, 0};
    tc_t = '{0, 0};
    rst2 = 1'b1;
    for (int c = 1; c <= 20050; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (en_base2 === 1'b1) begin
        if (nb < 3) tb_t[nb] = c;
        nb++;
      end
      if (en_ch2[0] === 1'b1) begin
        if (nc < 2) tc_t[nc] = c;
        nc++;
      end
    end
    chk("long first en_base", tb_t[0], 100);
    chk("long en_base period", tb_t[2] - tb_t[1], 100);
    chk("long en_base total", nb, 200);
    chk("long first en_ch0", tc_t[0], 10000);
    chk("long en_ch0 period", tc_t[1] - tc_t[0], 10000);
    chk("long en_ch0 total", nc, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/en_clk_multi.md
Name: en_clk_multi

Overview:
- Parametrised enable-pulse generator for the watch and clock datapath.
- A base prescaler derives a one-cycle en_base strobe at BASE_HZ from the system clock.
- NCH independent channel dividers further divide en_base by divisors that can be reloaded at runtime, for example 100 Hz to 1 Hz, 10 Hz or blink rates.
- Replaces fixed-rate per-frequency enable blocks; all downstream counters gate on en_base or en_ch[i].

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BASE_HZ, 100, base strobe rate. PRE_DIV = CLK_HZ/BASE_HZ; default 500000.
- CNT_W, 26, prescaler counter width. Must hold PRE_DIV-1.
- NCH, 4, number of channel dividers (1..16).
- DIV_W, 8, channel divisor and counter width.
- DIV_INIT, 100, divisor loaded into every channel at reset.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- run  in  1  1 = count; 0 = freeze all counters and suppress pulses.
- clr  in  1  synchronous clear of all counters (phase realign). Divisors are kept.
- load  in  1  single-cycle divisor load request.
- load_ch  in  max(1,$clog2(NCH))  target channel index.
- load_div  in  DIV_W  new divisor for load_ch.
- load_ack  out  1  one-cycle acknowledge of an accepted load.
- en_base  out  1  one-cycle strobe at BASE_HZ.
- en_ch  out  NCH  one-cycle strobe per channel at BASE_HZ/div[i].

Behaviour:
- Reset: reset is synchronous and active-low. Clock and reset ports are named clk and rst.
  - While rst=0 at an edge: prescaler=0, all ch_cnt=0, all div=DIV_INIT, en_base=0, en_ch=0, load_ack=0.
- Priority per edge: rst > clr > load > normal counting.
- Prescaler:
  - If run=1: when pre_cnt==PRE_DIV-1, set pre_cnt=0 and register en_base=1. Otherwise pre_cnt+1 and en_base=0.
  - If run=0: pre_cnt holds and en_base=0.
  - First en_base is high in the cycle after the PRE_DIV-th edge with rst=1 and run=1. Period thereafter is exactly PRE_DIV cycles.
- Define tick = run && (pre_cnt==PRE_DIV-1).
- Channel i:
  - On tick with div[i]>=1: if ch_cnt[i]==div[i]-1, set ch_cnt[i]=0 and en_ch[i]=1. Otherwise ch_cnt[i]+1 and en_ch[i]=0.
  - en_ch[i] is always coincident with en_base; never high without it.
  - div[i]==1: pulses on every en_base.
  - div[i]==0: channel disabled. ch_cnt held at 0, en_ch[i]=0.
  - On non-tick edges, en_ch[i]=0 and ch_cnt holds.
- Load:
  - When load=1 and load_ch<NCH: div[load_ch]=load_div and ch_cnt[load_ch]=0 at that edge. load_ack=1 for the next cycle only.
  - Any en_ch[load_ch] pulse that would fire on that edge is suppressed. Other channels are unaffected.
  - load_ch>=NCH: ignored, no ack.
  - load held high for several cycles: each cycle is a fresh load and ack, so repeats are permitted.
  - Load is accepted regardless of run.
- clr=1: pre_cnt=0, all ch_cnt=0, en_base=0, en_ch=0, load_ack=0. div values are retained and load is ignored that cycle. After clr deasserts, timing matches a fresh reset.
- Widths: counters wrap only via terminal compare, never by overflow. Arithmetic is unsigned.
- Elaboration errors:
  - CLK_HZ % BASE_HZ != 0.
  - PRE_DIV < 2.
  - PRE_DIV-1 >= 2**CNT_W.
  - DIV_INIT >= 2**DIV_W.
- All outputs are registered. There are no combinational input-to-output paths.

Decomposition:
- Package en_clk_pkg:
  - Function pre_div(clk_hz, base_hz).
  - Localparam helper for the channel-index width.
  - Constant CNT_W_MIN computed via $clog2.
- Sub-module en_div_ch: one channel.
  - Inputs: clk, rst, clr, tick, ld, ld_div.
  - Outputs: en, div.
  - Instantiated NCH times by generate.
- Top level holds the prescaler, the load decode and load_ack.

Test Plan:
1. CLK_HZ=100, BASE_HZ=10 (PRE_DIV=10), NCH=2, DIV_INIT=3; release rst with run=1 -> en_base high in cycles 10, 20, 30, ...; en_ch[0] and en_ch[1] high together with the 3rd, 6th, ... en_base only.
2. Same config; drop run for 7 cycles midway through a period -> en_base period stretches to exactly 17 cycles; no pulses while run=0.
3. load=1, load_ch=1, load_div=1 on the same edge ch1 would fire -> ch1 pulse suppressed; load_ack high 1 cycle; ch1 then pulses on every en_base; ch0 unchanged.
4. load_div=0 to ch0 -> en_ch[0] never asserts over 100 cycles; load_ch=2 (>=NCH) -> no load_ack, no state change.
5. Assert clr at pre_cnt=5 -> next en_base exactly 10 cycles after clr deasserts; divisors retained; asserting rst at the same edge overrides clr.
6. Default params (PRE_DIV=500000, DIV_INIT=100) -> en_base period 500000 cycles; en_ch[0] period 50000000 cycles (1 Hz).
